// File: rtl/mem_if_pkg.sv
// Shared types and constants for the core/memory load-store handshake.
// Holds the responder FSM encoding and helpers for the flattened per-core buses.
package mem_if_pkg;

   localparam int WIDTH_DEF   = 32;
   localparam int N_CORES_DEF = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2,
      TURN    = 2'd3
   } state_t;

   // Low bit of core idx's word inside a flattened N*w bus.
   function automatic int slice_lo(input int idx, input int w);
      return idx * w;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or after rr_ptr,
// wrapping modulo N_CORES.
module rr_arbiter
   import mem_if_pkg::*;
#(
   parameter int N_CORES = N_CORES_DEF,
   parameter int IDX_W   = 2
) (
   input  logic [N_CORES-1:0] eligible,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic               grant_valid,
   output logic [IDX_W-1:0]   grant_idx
);

   int cand;

   // Scan from farthest to nearest so the closest eligible core wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int k = N_CORES - 1; k >= 0; k--) begin
         cand = (int'(rr_ptr) + k) % N_CORES;
         if (eligible[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = IDX_W'(cand);
         end else begin
            grant_valid = grant_valid;
         end
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side endpoint serving N_CORES cores against one single-port word RAM,
// one round-robin-arbitrated transaction at a time.
module mem_responder
   import mem_if_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int N_CORES = N_CORES_DEF,
   parameter int IDX_W   = 2,
   parameter int DEPTH   = 1024
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_CORES-1:0]         request,
   input  logic [N_CORES-1:0]         wren,
   input  logic [N_CORES*WIDTH-1:0]   address,
   input  logic [N_CORES*WIDTH-1:0]   writedata,
   output logic [N_CORES-1:0]         response,
   output logic [WIDTH-1:0]           readdata,
   output logic                       busy,
   output logic [15:0]                err_count
);

   localparam int AW = $clog2(DEPTH);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;
   logic [WIDTH-1:0]     addr_q, addr_d;
   logic                 wren_q, wren_d;
   logic [WIDTH-1:0]     wdata_q, wdata_d;
   logic [N_CORES-1:0]   lockout_q, lockout_d;
   logic [N_CORES-1:0]   response_q, response_d;
   logic [WIDTH-1:0]     readdata_q, readdata_d;
   logic                 busy_q, busy_d;
   logic [15:0]          err_count_q, err_count_d;
   logic [WIDTH-1:0]     ram_rd_q;
   logic [WIDTH-1:0]     mem_q [DEPTH];

   logic [N_CORES-1:0]   eligible_s;
   logic                 grant_valid_s;
   logic [IDX_W-1:0]     grant_idx_s;
   logic                 in_range_s;
   logic [AW-1:0]        ram_idx_s;

   assign eligible_s = request & ~lockout_q;
   assign in_range_s = (addr_q < WIDTH'(DEPTH));
   assign ram_idx_s  = addr_q[AW-1:0];

   rr_arbiter #(.N_CORES(N_CORES), .IDX_W(IDX_W)) u_arb (
      .eligible    (eligible_s),
      .rr_ptr      (rr_ptr_q),
      .grant_valid (grant_valid_s),
      .grant_idx   (grant_idx_s)
   );

   // Next-state and output logic of the transaction FSM.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      gnt_idx_d   = gnt_idx_q;
      addr_d      = addr_q;
      wren_d      = wren_q;
      wdata_d     = wdata_q;
      lockout_d   = lockout_q;
      response_d  = '0;
      readdata_d  = '0;
      err_count_d = err_count_q;
      case (state_q)
         IDLE: begin
            if (grant_valid_s) begin
               state_d   = ACCESS;
               gnt_idx_d = grant_idx_s;
               addr_d    = address[slice_lo(int'(grant_idx_s), WIDTH) +: WIDTH];
               wdata_d   = writedata[slice_lo(int'(grant_idx_s), WIDTH) +: WIDTH];
               wren_d    = wren[grant_idx_s];
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            state_d = RESPOND;
            if (!in_range_s && (err_count_q != 16'hFFFF)) begin
               err_count_d = err_count_q + 16'd1;
            end else begin
               err_count_d = err_count_q;
            end
         end
         RESPOND: begin
            state_d                = TURN;
            response_d[gnt_idx_q]  = 1'b1;
            lockout_d[gnt_idx_q]   = 1'b1;
            rr_ptr_d = (gnt_idx_q == IDX_W'(N_CORES - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
            if (wren_q || !in_range_s) begin
               readdata_d = '0;
            end else begin
               readdata_d = ram_rd_q;
            end
         end
         TURN: begin
            // The stale request level is masked until this edge returns us to IDLE.
            state_d   = IDLE;
            lockout_d = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // FSM, latched transaction and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         gnt_idx_q   <= '0;
         addr_q      <= '0;
         wren_q      <= 1'b0;
         wdata_q     <= '0;
         lockout_q   <= '0;
         response_q  <= '0;
         readdata_q  <= '0;
         busy_q      <= 1'b0;
         err_count_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         gnt_idx_q   <= gnt_idx_d;
         addr_q      <= addr_d;
         wren_q      <= wren_d;
         wdata_q     <= wdata_d;
         lockout_q   <= lockout_d;
         response_q  <= response_d;
         readdata_q  <= readdata_d;
         busy_q      <= busy_d;
         err_count_q <= err_count_d;
      end
   end

   // Single RAM port; reset drops the FSM out of ACCESS, so an aborted write never commits.
   always_ff @(posedge clk) begin
      if ((state_q == ACCESS) && in_range_s) begin
         if (wren_q) begin
            mem_q[ram_idx_s] <= wdata_q;
         end else begin
            ram_rd_q <= mem_q[ram_idx_s];
         end
      end
   end

   assign response  = response_q;
   assign readdata  = readdata_q;
   assign busy      = busy_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table plus hand-written
// contention, held-request, lockout and reset sequences, scoreboarded responses.
module tb_mem_responder;

   localparam int W = 32;
   localparam int N = 4;
   localparam int D = 1024;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   request, wren, response;
   logic [N*W-1:0] address, writedata;
   logic [W-1:0]   readdata;
   logic           busy;
   logic [15:0]    err_count;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {int core; logic [W-1:0] rdata;} exp_t;
   exp_t sbq[$];
   exp_t mon_e;
   logic [W-1:0] model [int];

   typedef struct {
      int          core;
      logic        wr;
      logic [W-1:0] addr;
      logic [W-1:0] data;
      logic [W-1:0] exp_rd;
      logic [15:0]  exp_err;
   } vec_t;
   vec_t tbl [11];

   mem_responder #(.WIDTH(W), .N_CORES(N), .IDX_W(2), .DEPTH(D)) dut (
      .clk       (clk),
      .reset     (reset),
      .request   (request),
      .wren      (wren),
      .address   (address),
      .writedata (writedata),
      .response  (response),
      .readdata  (readdata),
      .busy      (busy),
      .err_count (err_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard: every response pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (response !== '0) begin
         if (sbq.size() == 0) begin
            chk("unexpected_resp", 32'(response), 32'd0);
         end else begin
            mon_e = sbq.pop_front();
            chk("resp_vec", 32'(response), 32'd1 << mon_e.core);
            chk("rdata", readdata, mon_e.rdata);
         end
      end
   end

   task automatic drive(input int c, input logic wr, input logic [W-1:0] a, input logic [W-1:0] d);
      request[c]         = 1'b1;
      wren[c]            = wr;
      address[c*W +: W]  = a;
      writedata[c*W +: W] = d;
   endtask

   task automatic push(input int c, input logic [W-1:0] rd);
      exp_t e;
      e.core  = c;
      e.rdata = rd;
      sbq.push_back(e);
   endtask

   task automatic mupd(input logic wr, input logic [W-1:0] a, input logic [W-1:0] d);
      if (wr && a < D) model[int'(a)] = d;
   endtask

   function automatic logic [W-1:0] mexp(input logic wr, input logic [W-1:0] a);
      if (wr || a >= D) return '0;
      if (model.exists(int'(a))) return model[int'(a)];
      return 'x;
   endfunction

   task automatic wait_resp(input string nm, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (response == '0 && lat < 16);
      if (response == '0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no response expected one within 16 cycles", nm);
      end
   endtask

   // Called just after a rising edge with the DUT idle; returns just after a rising edge.
   task automatic txn(input int c, input logic wr, input logic [W-1:0] a, input logic [W-1:0] d,
                      input logic [W-1:0] exp_rd, input string nm);
      int lat;
      drive(c, wr, a, d);
      push(c, exp_rd);
      mupd(wr, a, d);
      @(negedge clk);
      @(negedge clk);
      chk({nm, "_busy"}, 32'(busy), 32'd1);
      wait_resp(nm, lat);
      chk({nm, "_lat"}, lat, 32'd2);
      @(posedge clk);
      #1 request[c] = 1'b0;
   endtask

   task automatic serve(input int n, input string nm);
      int last, lat, c;
      last = -1;
      for (int k = 0; k < n; k++) begin
         wait_resp(nm, lat);
         c = -1;
         for (int j = 0; j < N; j++) if (response[j]) c = j;
         if (last >= 0) chk({nm, "_spacing"}, cyc - last, 32'd4);
         last = cyc;
         @(posedge clk);
         #1;
         if (c >= 0) request[c] = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1);
   end

   initial begin
      int lat;
      tbl[0]  = '{0, 1'b1, 32'd5,          32'hDEADBEEF, 32'd0,         16'd0};
      tbl[1]  = '{0, 1'b0, 32'd5,          32'd0,        32'hDEADBEEF,  16'd0};
      tbl[2]  = '{1, 1'b1, 32'd10,         32'h11111111, 32'd0,         16'd0};
      tbl[3]  = '{3, 1'b1, 32'd1023,       32'hCAFEF00D, 32'd0,         16'd0};
      tbl[4]  = '{2, 1'b0, 32'd10,         32'd0,        32'h11111111,  16'd0};
      tbl[5]  = '{3, 1'b0, 32'd1023,       32'd0,        32'hCAFEF00D,  16'd0};
      tbl[6]  = '{1, 1'b0, 32'd1024,       32'd0,        32'd0,         16'd1};
      tbl[7]  = '{2, 1'b1, 32'hFFFF_FFFF,  32'h12345678, 32'd0,         16'd2};
      tbl[8]  = '{0, 1'b0, 32'd1023,       32'd0,        32'hCAFEF00D,  16'd2};
      tbl[9]  = '{0, 1'b1, 32'd0,          32'hA5A5A5A5, 32'd0,         16'd2};
      tbl[10] = '{1, 1'b0, 32'd0,          32'd0,        32'hA5A5A5A5,  16'd2};

      reset = 1'b1;
      request = '0; wren = '0; address = '0; writedata = '0;
      @(negedge clk);
      chk("rst_response", 32'(response), 32'd0);
      chk("rst_readdata", readdata, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err_count), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 11; i++) begin
         txn(tbl[i].core, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].exp_rd, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d_err", i), 32'(err_count), 32'(tbl[i].exp_err));
      end

      // Reset while the write is in ACCESS: aborted, then re-granted after release.
      drive(0, 1'b1, 32'd300, 32'h77777777);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midrst_response", 32'(response), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_err", 32'(err_count), 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      push(0, 32'd0);
      mupd(1'b1, 32'd300, 32'h77777777);
      wait_resp("midrst_regrant", lat);
      chk("midrst_lat", lat, 32'd3);
      @(posedge clk);
      #1 request[0] = 1'b0;
      txn(3, 1'b0, 32'd300, 32'd0, 32'h77777777, "midrst_readback");

      // Contention at rr_ptr=0: expect 0, 1, 3; then 0 before 1 shows the pointer wrapped to 0.
      for (int c = 0; c < N; c++) begin
         if (c != 2) begin
            drive(c, 1'b1, 32'(400 + c), 32'(32'hC0DE0000 + c));
            mupd(1'b1, 32'(400 + c), 32'(32'hC0DE0000 + c));
            push(c, 32'd0);
         end
      end
      serve(3, "contend");
      drive(1, 1'b0, 32'd401, 32'd0);
      drive(0, 1'b0, 32'd400, 32'd0);
      push(0, mexp(1'b0, 32'd400));
      push(1, mexp(1'b0, 32'd401));
      serve(2, "ptrwrap");

      // Held request: core 2 advances its address after each response.
      for (int k = 0; k < 8; k++) begin
         drive(2, 1'b1, 32'(100 + k), 32'(32'hB0000000 + k * 3));
         mupd(1'b1, 32'(100 + k), 32'(32'hB0000000 + k * 3));
         push(2, 32'd0);
         wait_resp($sformatf("held%0d", k), lat);
         chk($sformatf("held%0d_lat", k), lat, 32'd4);
         @(posedge clk);
         #1;
      end
      request[2] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("held_no_extra", 32'(sbq.size()), 32'd0);
      for (int k = 0; k < 8; k++) begin
         txn(2, 1'b0, 32'(100 + k), 32'd0, 32'(32'hB0000000 + k * 3), $sformatf("heldrd%0d", k));
      end

      // Lockout: request left high with the same address into the cycle after the response.
      drive(1, 1'b1, 32'd200, 32'h5A5A0001);
      mupd(1'b1, 32'd200, 32'h5A5A0001);
      push(1, 32'd0);
      wait_resp("lockout", lat);
      chk("lockout_lat", lat, 32'd4);
      @(posedge clk);
      #6 request[1] = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("lockout_single", 32'(sbq.size()), 32'd0);
      txn(1, 1'b0, 32'd200, 32'd0, 32'h5A5A0001, "lockout_rd");

      chk("final_sb_empty", 32'(sbq.size()), 32'd0);
      chk("final_busy", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side endpoint of the core load/store handshake (request, wren, address, writedata / response, readdata).
- Serves N_CORES cores against one internal single-port synchronous word RAM.
- Round-robin arbitration; one transaction in flight at a time.
- Sits between the core array and data memory; cores stall until their response pulse.

Parameters:
- WIDTH, 32, data/address word width
- N_CORES, 4, number of requesting cores
- IDX_W, 2, width of the core index (clog2 of N_CORES)
- DEPTH, 1024, RAM words; valid addresses are 0..DEPTH-1

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- request  in  N_CORES  per-core request level
- wren  in  N_CORES  per-core write enable (1 = write, 0 = read)
- address  in  N_CORES*WIDTH  flattened per-core word address; core i occupies bits [i*WIDTH +: WIDTH]
- writedata  in  N_CORES*WIDTH  flattened per-core write data, same packing
- response  out  N_CORES  per-core one-cycle completion pulse
- readdata  out  WIDTH  shared read data; valid only while some response bit is high
- busy  out  1  high in any state other than IDLE
- err_count  out  16  out-of-range access count, saturating at 16'hFFFF

Behaviour:
- Reset (asynchronous, active-high) clears all outputs immediately: response=0, readdata=0, busy=0, err_count=0.
- Reset also forces FSM=IDLE and rr_ptr=0. RAM contents are not cleared.
- Reset during any state aborts the transaction. A write not yet committed is dropped, and no response is issued.
- FSM has four states:
  - IDLE: eligible = request & ~lockout. If eligible != 0, grant the first set bit at or after rr_ptr (wrapping modulo N_CORES). Latch the grant index, address, wren and writedata, then go to ACCESS.
  - ACCESS: if address < DEPTH, a write commits mem[addr]=writedata and a read issues a RAM read. If address >= DEPTH, a write is dropped, a read returns 0, and err_count increments. Go to RESPOND.
  - RESPOND: response[g]=1 for exactly this cycle. readdata = RAM data for reads; 0 for writes and for out-of-range reads. Set lockout[g]=1, set rr_ptr=(g+1) mod N_CORES, then go to TURN.
  - TURN: lockout[g] remains set. Go to IDLE; lockout clears on the IDLE entry edge.
- Lockout is required because the core drops request on the same edge it samples response. Without it, the stale high level would be re-granted.
- Request held high past TURN with a changed address is a new transaction. Register-dump sequences rely on this.
- Latency: request sampled in IDLE at edge N gives response high from edge N+2 to N+3. Minimum period per transaction is 4 cycles.
- Inputs from the granted core are latched at grant. Later changes to them do not affect the transaction in flight.
- A request dropped after grant still completes and pulses response. The core ignores it.
- Simultaneous requests: the round-robin pointer guarantees each requester is served within N_CORES transactions.
- Non-granted requests stay pending; their response bits stay 0.
- Address comparison is unsigned on the full WIDTH bits. The RAM index uses the low clog2(DEPTH) bits only when the address is in range.
- err_count saturates at its maximum and does not wrap.
- At most one response bit is high in any cycle (onehot0).

Decomposition:
- Shared package mem_if_pkg holds:
  - FSM state encoding (IDLE=0, ACCESS=1, RESPOND=2, TURN=3)
  - slice helper constants for the flattened buses
  - defaults for WIDTH and N_CORES
- Sub-module rr_arbiter (parameter N_CORES):
  - inputs: eligible vector, rr_ptr
  - outputs: grant_valid, grant_idx
  - purely combinational; rr_ptr update stays in mem_responder.
- RAM is an inferred array inside mem_responder, not a separate module.

Test Plan:
- Single write then read: core 0 writes 32'hDEADBEEF to address 5 (response at N+2); core 0 then reads address 5 -> readdata=32'hDEADBEEF with response[0] pulse; response[1..3]=0 throughout.
- Contention: cores 0, 1 and 3 raise request together at rr_ptr=0 -> served in order 0, 1, 3 at 4-cycle spacing; rr_ptr ends at 0.
- Held request / dump emulation: core 2 holds request high for 8 consecutive writes, advancing the address 100..107 after each response -> 8 responses, 4 cycles apart, mem[100..107] correct, no duplicate write at any address.
- Lockout: core 1 keeps its request high for one cycle after its response with the address unchanged -> no re-grant during TURN; a write occurs only once.
- Out of range: read of address DEPTH and write to 32'hFFFF_FFFF -> readdata=0, RAM unchanged, err_count=2, responses still issued.
- Reset mid-transaction: assert reset while in ACCESS during a write -> response stays 0, busy=0 immediately; after release the same request is re-granted and completes normally.
